eeg_spi_sampler: RTL and testbench
==================================

EEG_SPI_SAMPLER -- requirements
Module: eeg_spi_sampler

Interface
REQ-001 The block SHALL have parameter NCH, default 8, number of EEG channels per frame (1..8).
REQ-002 The block SHALL have parameter CLK_DIV, default 4, clk cycles per SCLK half-period (>=2).
REQ-003 The block SHALL have port clk, input, 1, system clock.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-005 The block SHALL have port drdy_n, input, 1, asynchronous ADC data-ready, active-low.
REQ-006 The block SHALL have port spi_miso, input, 1, ADC serial data.
REQ-007 The block SHALL have port spi_cs_n, output, 1, ADC chip select, active-low.
REQ-008 The block SHALL have port spi_sclk, output, 1, SPI clock, idle low.
REQ-009 The block SHALL have port spi_mosi, output, 1, held 0 at all times.
REQ-010 The block SHALL have port valid, output, 1, one-cycle strobe per channel sample; drives the filter's valid.
REQ-011 The block SHALL have port x_out, output, 16, signed sample; drives the filter's x_in.
REQ-012 The block SHALL have port ch_idx, output, 3, channel number of x_out (0..NCH-1).
REQ-013 The block SHALL have port busy, output, 1, high when state is not IDLE.
REQ-014 The block SHALL have ports frame_err and overrun, output, 1 each, one-cycle error strobes.

Function
REQ-015 drdy_n SHALL pass through a 2-flop synchronizer; a frame start SHALL be a 1-to-0 transition of the synchronized value.
REQ-016 States SHALL be IDLE, CS_SETUP, SHIFT, CS_HOLD; IDLE->CS_SETUP on frame start; CS_SETUP->SHIFT after CLK_DIV cycles; SHIFT->CS_HOLD after the last bit; CS_HOLD->IDLE after CLK_DIV cycles.
REQ-017 spi_cs_n SHALL be 0 in CS_SETUP, SHIFT and CS_HOLD, and 1 in IDLE.
REQ-018 A frame SHALL be 24 status bits then NCH x 24 channel bits, MSB first, i.e. 24*(NCH+1) SCLK periods.
REQ-019 Each SCLK period SHALL be 2*CLK_DIV cycles: high for the first CLK_DIV, then low for the remaining CLK_DIV.
REQ-020 spi_miso SHALL be captured on the last clk cycle of each low half.
REQ-021 After each channel word's 24th bit is captured, valid SHALL pulse on the next cycle with x_out = word[23:8] (truncation, no rounding) and ch_idx = channel.
REQ-022 x_out and ch_idx SHALL hold their values until the next valid.
REQ-023 A frame start detected while busy SHALL pulse overrun for one cycle and SHALL be otherwise ignored; the current frame continues.
REQ-024 Frame starts SHALL be detected only in IDLE or as overrun; the edge is not queued.

Reset
REQ-025 On rst: state IDLE, spi_cs_n=1, spi_sclk=0, spi_mosi=0, valid=0, x_out=0, ch_idx=0, busy=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-026 rst asserted mid-frame SHALL abort the frame on the next edge with no valid pulse; a following frame starts cleanly.

Configuration
REQ-027 With EEG_SPI_STATUS_CHECK_EN defined, the block SHALL check status[23:20]==4'b1100.
REQ-028 On a status mismatch with the macro defined, frame_err SHALL pulse one cycle after status bit 24 is captured; all valid pulses of that frame SHALL be suppressed, and the frame SHALL still be clocked out fully.
REQ-029 Without EEG_SPI_STATUS_CHECK_EN, the status word SHALL be ignored and frame_err SHALL be tied 0.

Verification
REQ-030 NCH=2, CLK_DIV=4, status 0xC00000, ch0=0x123456, ch1=0xFEDCBA -> valid x_out=0x1234 ch_idx=0, then 0xFEDC ch_idx=1, exactly 72 SCLK periods, cs_n low for 72*8+8 cycles.
REQ-031 Drive drdy_n low again mid-SHIFT -> overrun pulses exactly one cycle; still exactly 2 valids in the frame; no second frame starts.
REQ-032 With macro defined, status 0x800000 -> frame_err one cycle, zero valids, cs_n returns high on schedule; without macro -> 2 valids, frame_err 0.
REQ-033 Assert rst for 1 cycle after 30 SCLK periods -> cs_n=1 and sclk=0 the next cycle, no valid; the next drdy frame yields correct samples.
REQ-034 ch0 = 0x7FFFFF then 0x800000 over two frames -> x_out = 0x7FFF then 0x8000; spi_mosi stays 0 throughout.

Source files
------------

// File: rtl/eeg_spi_sampler.sv
// SPI frame sampler for an EEG ADC: waits for data-ready and clocks out one status word plus NCH channel words.
// Each channel word's upper 16 bits are emitted as a one-cycle valid strobe. Define EEG_SPI_STATUS_CHECK_EN to validate the status header.
`timescale 1ns/1ps

module eeg_spi_sampler #(
    parameter int NCH     = 8,
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        drdy_n,
    input  logic        spi_miso,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        valid,
    output logic [15:0] x_out,
    output logic [2:0]  ch_idx,
    output logic        busy,
    output logic        frame_err,
    output logic        overrun
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

    state_t          state, state_n;
    logic            drdy_s1, drdy_s2, drdy_prev;
    logic            frame_start;
    logic [DW-1:0]   div_cnt;
    logic            div_last;
    logic            half_low, half_low_n;
    logic            sclk_n;
    logic            capture;
    logic [4:0]      bit_in_word;
    logic [3:0]      word_idx;
    logic            last_bit;
    logic [22:0]     shreg;
    logic            bad_frame;

    assign spi_mosi = 1'b0;

    // drdy_n is asynchronous to clk; a falling edge after two flops marks a new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            drdy_s1   <= 1'b1;
            drdy_s2   <= 1'b1;
            drdy_prev <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            drdy_s1   <= drdy_n;
            drdy_s2   <= drdy_s1;
            drdy_prev <= drdy_s2;
        end
    end

    assign frame_start = drdy_prev & ~drdy_s2;
    assign div_last    = (div_cnt == DW'(CLK_DIV - 1));
    assign capture     = (state == SHIFT) && half_low && div_last;
    assign last_bit    = capture && (bit_in_word == 5'd23) && (word_idx == 4'(NCH));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_n    = state;
        half_low_n = 1'b0;
        case (state)
            IDLE:     if (frame_start) state_n = CS_SETUP;
            CS_SETUP: if (div_last)    state_n = SHIFT;
            SHIFT: begin
                half_low_n = div_last ? ~half_low : half_low;
                if (last_bit) state_n = CS_HOLD;
            end
            CS_HOLD:  if (div_last)    state_n = IDLE;
            default:                   state_n = IDLE;
        endcase
        sclk_n = (state_n == SHIFT) && !half_low_n;
    end

    // SPI pins and busy are registered from next-state values so they are glitch-free yet cycle-aligned with state.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            half_low    <= 1'b0;
            bit_in_word <= '0;
            word_idx    <= '0;
            shreg       <= '0;
            bad_frame   <= 1'b0;
            spi_cs_n    <= 1'b1;
            spi_sclk    <= 1'b0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            x_out       <= '0;
            ch_idx      <= '0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= frame_start && (state != IDLE);
            spi_cs_n  <= (state_n == IDLE);
            spi_sclk  <= sclk_n;
            busy      <= (state_n != IDLE);
            half_low  <= half_low_n;

            if (state == IDLE || div_last) div_cnt <= '0;
            else                           div_cnt <= div_cnt + 1'b1;

            if (state == IDLE) begin
                bit_in_word <= '0;
                word_idx    <= '0;
                bad_frame   <= 1'b0;
            end else if (capture) begin
                shreg <= {shreg[21:0], spi_miso};
                if (bit_in_word == 5'd23) begin
                    bit_in_word <= '0;
                    word_idx    <= word_idx + 1'b1;
                    if (word_idx == 4'd0) begin
`ifdef EEG_SPI_STATUS_CHECK_EN
                        // Status header bits [23:20] must read 4'b1100; otherwise drop this frame's samples.
                        if (shreg[22:19] != 4'b1100) begin
                            frame_err <= 1'b1;
                            bad_frame <= 1'b1;
                        end
`endif
                    end else if (!bad_frame) begin
                        // The completed word is {shreg, spi_miso}; its top 16 bits sit in shreg[22:7].
                        valid  <= 1'b1;
                        x_out  <= shreg[22:7];
                        ch_idx <= 3'(word_idx - 4'd1);
                    end
                end else begin
                    bit_in_word <= bit_in_word + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_eeg_spi_sampler.sv
// Directed bench for eeg_spi_sampler with NCH=2, CLK_DIV=4 and a behavioural ADC shifting data on SCLK rise.
// Expected values are hand-computed; the status-check macro only changes the bad-status expectations.
`timescale 1ns/1ps

module tb_eeg_spi_sampler;

    logic        clk = 1'b0;
    logic        rst;
    logic        drdy_n;
    logic        spi_miso = 1'b0;
    logic        spi_cs_n, spi_sclk, spi_mosi;
    logic        valid;
    logic [15:0] x_out;
    logic [2:0]  ch_idx;
    logic        busy, frame_err, overrun;

    eeg_spi_sampler #(.NCH(2), .CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .drdy_n(drdy_n), .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .valid(valid), .x_out(x_out), .ch_idx(ch_idx), .busy(busy),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ADC model: next bit appears on each SCLK rise, pointer restarts when chip select falls.
    logic [71:0] frame_word = '0;
    int          bit_ptr    = 0;

    always @(negedge spi_cs_n or posedge spi_sclk) begin
        if (spi_sclk) begin
            if (bit_ptr < 72) spi_miso = frame_word[71 - bit_ptr];
            bit_ptr++;
        end else begin
            bit_ptr = 0;
        end
    end

    // Observation counters, cleared by clr, sampled on the falling clock edge.
    logic        clr = 1'b0;
    int          vcnt, ov_cnt, fe_cnt, cs_low, rises, mosi_bad = 0;
    logic        sclk_prev = 1'b0;
    logic [15:0] vx [0:3];
    logic [2:0]  vch[0:3];
    int          vt [0:3];

    always @(negedge clk) begin
        if (spi_mosi !== 1'b0) mosi_bad++;
        if (clr) begin
            vcnt = 0; ov_cnt = 0; fe_cnt = 0; cs_low = 0; rises = 0;
        end else begin
            if (!spi_cs_n) cs_low++;
            if (spi_sclk && !sclk_prev) rises++;
            if (overrun) ov_cnt++;
            if (frame_err) fe_cnt++;
            if (valid) begin
                if (vcnt < 4) begin
                    vx[vcnt]  = x_out;
                    vch[vcnt] = ch_idx;
                    vt[vcnt]  = cs_low;
                end
                vcnt++;
            end
        end
        sclk_prev = spi_sclk;
    end

    task automatic clear_mon();
        @(posedge clk); clr = 1'b1;
        @(posedge clk); clr = 1'b0;
    endtask

    task automatic wait_cs(input logic level, input string tag);
        int n = 0;
        while (spi_cs_n !== level && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(spi_cs_n), 32'(level));
    endtask

    task automatic wait_sclk(input int target);
        int n = 0;
        while (rises < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("sclk_reached", 32'(rises >= target), 32'd1);
    endtask

    task automatic run_frame(input logic [71:0] fw);
        clear_mon();
        frame_word = fw;
        drdy_n = 1'b0;
        wait_cs(1'b0, "cs_fall");
        wait_cs(1'b1, "cs_rise");
        drdy_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        drdy_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cs_n",  32'(spi_cs_n),  32'd1);
        check("rst_sclk",  32'(spi_sclk),  32'd0);
        check("rst_mosi",  32'(spi_mosi),  32'd0);
        check("rst_valid", 32'(valid),     32'd0);
        check("rst_x_out", 32'(x_out),     32'd0);
        check("rst_ch_idx",32'(ch_idx),    32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_ferr",  32'(frame_err), 32'd0);
        check("rst_ovr",   32'(overrun),   32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Nominal frame: timing of valids, SCLK count and chip-select width.
        clear_mon();
        frame_word = {24'hC00000, 24'h123456, 24'hFEDCBA};
        drdy_n = 1'b0;
        wait_cs(1'b0, "cs_fall");
        check("busy_in_frame", 32'(busy), 32'd1);
        wait_cs(1'b1, "cs_rise");
        drdy_n = 1'b1;
        repeat (6) @(negedge clk);
        check("nom_vcnt",   32'(vcnt),   32'd2);
        check("nom_x0",     32'(vx[0]),  32'h1234);
        check("nom_ch0",    32'(vch[0]), 32'd0);
        check("nom_t0",     32'(vt[0]),  32'd389);
        check("nom_x1",     32'(vx[1]),  32'hFEDC);
        check("nom_ch1",    32'(vch[1]), 32'd1);
        check("nom_t1",     32'(vt[1]),  32'd581);
        check("nom_rises",  32'(rises),  32'd72);
        check("nom_cs_low", 32'(cs_low), 32'd584);
        check("nom_ovr",    32'(ov_cnt), 32'd0);
        check("nom_ferr",   32'(fe_cnt), 32'd0);
        check("hold_x_out", 32'(x_out),  32'hFEDC);
        check("hold_ch",    32'(ch_idx), 32'd1);
        check("idle_busy",  32'(busy),   32'd0);

        // Second drdy falling edge mid-SHIFT: overrun strobe only.
        clear_mon();
        frame_word = {24'hC00000, 24'hABCDEF, 24'h00FF00};
        drdy_n = 1'b0;
        wait_cs(1'b0, "ovr_cs_fall");
        wait_sclk(10);
        drdy_n = 1'b1;
        repeat (6) @(negedge clk);
        drdy_n = 1'b0;
        wait_cs(1'b1, "ovr_cs_rise");
        repeat (40) @(negedge clk);
        check("ovr_no_restart", 32'(spi_cs_n), 32'd1);
        check("ovr_idle_busy",  32'(busy),     32'd0);
        check("ovr_cnt",        32'(ov_cnt),   32'd1);
        check("ovr_vcnt",       32'(vcnt),     32'd2);
        check("ovr_x0",         32'(vx[0]),    32'hABCD);
        check("ovr_x1",         32'(vx[1]),    32'h00FF);
        check("ovr_cs_low",     32'(cs_low),   32'd584);
        drdy_n = 1'b1;
        repeat (6) @(negedge clk);

        // Bad status header.
        run_frame({24'h800000, 24'h111111, 24'h222222});
        check("bad_cs_low", 32'(cs_low), 32'd584);
`ifdef EEG_SPI_STATUS_CHECK_EN
        check("bad_ferr",  32'(fe_cnt), 32'd1);
        check("bad_vcnt",  32'(vcnt),   32'd0);
        check("bad_hold",  32'(x_out),  32'h00FF);
`else
        check("bad_ferr",  32'(fe_cnt), 32'd0);
        check("bad_vcnt",  32'(vcnt),   32'd2);
        check("bad_x1",    32'(vx[1]),  32'h2222);
`endif

        // Reset mid-frame after 30 SCLK periods.
        clear_mon();
        frame_word = {24'hC00000, 24'h0F0F0F, 24'h707070};
        drdy_n = 1'b0;
        wait_cs(1'b0, "rst_cs_fall");
        wait_sclk(30);
        @(negedge clk);
        rst    = 1'b1;
        drdy_n = 1'b1;
        @(negedge clk);
        check("abort_cs_n", 32'(spi_cs_n), 32'd1);
        check("abort_sclk", 32'(spi_sclk), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_vcnt", 32'(vcnt), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        run_frame({24'hC00000, 24'h246813, 24'h13579B});
        check("post_vcnt",   32'(vcnt),   32'd2);
        check("post_x0",     32'(vx[0]),  32'h2468);
        check("post_ch0",    32'(vch[0]), 32'd0);
        check("post_x1",     32'(vx[1]),  32'h1357);
        check("post_cs_low", 32'(cs_low), 32'd584);

        // Signed extremes: truncation without rounding.
        run_frame({24'hC00000, 24'h7FFFFF, 24'h000100});
        check("max_x0", 32'(vx[0]), 32'h7FFF);
        check("max_x1", 32'(vx[1]), 32'h0001);
        run_frame({24'hC00000, 24'h800000, 24'hFFFFFF});
        check("min_x0", 32'(vx[0]), 32'h8000);
        check("min_x1", 32'(vx[1]), 32'hFFFF);
        check("mosi_low", 32'(mosi_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
